// File: rtl/pc_redirect_ctrl_if.sv
// Front-end redirect bus: ID/EX redirect sources in, registered PC-mux
// select, squash pulses and status out.
interface pc_redirect_ctrl_if;
    logic        stall;
    logic        jump_id;
    logic [25:0] jump_addr_id;
    logic [31:0] pc_plus_4_id;
    logic        branch_taken_ex;
    logic [31:0] branch_target_ex;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        busy;
    logic [15:0] redirect_count;

    modport master (
        output stall, jump_id, jump_addr_id, pc_plus_4_id,
               branch_taken_ex, branch_target_ex,
        input  redirect_valid, redirect_pc, flush_if_id, flush_id_ex,
               busy, redirect_count
    );

    modport slave (
        input  stall, jump_id, jump_addr_id, pc_plus_4_id,
               branch_taken_ex, branch_target_ex,
        output redirect_valid, redirect_pc, flush_if_id, flush_id_ex,
               busy, redirect_count
    );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// PC redirect controller: merges the EX branch and ID jump into one
// registered redirect, holding it across stalls and masking wrong-path events.
module pc_redirect_ctrl #(
    parameter logic [15:0] CNT_SAT = 16'hFFFF
) (
    input logic               clock,
    input logic               reset,
    pc_redirect_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        pend_br_q, pend_br_d;
    logic        valid_q;
    logic [31:0] pc_q;
    logic        flush_if_id_q;
    logic        flush_id_ex_q;
    logic [15:0] count_q;

    logic        ev;
    logic        sel_br;
    logic [31:0] sel_pc;
    logic [31:0] jump_tgt;
    logic        fire;
    logic [31:0] fire_pc;
    logic        fire_br;

    // Region bits come straight from PC+4; the index never carries into them.
    assign jump_tgt = {bus.pc_plus_4_id[31:28], bus.jump_addr_id, 2'b00};
    assign ev       = bus.branch_taken_ex | bus.jump_id;
    // The EX branch is the older instruction, so it beats a same-cycle jump.
    assign sel_br   = bus.branch_taken_ex;
    assign sel_pc   = bus.branch_taken_ex ? bus.branch_target_ex : jump_tgt;

    always_comb begin
        state_d   = state_q;
        pend_pc_d = pend_pc_q;
        pend_br_d = pend_br_q;
        fire      = 1'b0;
        fire_pc   = pend_pc_q;
        fire_br   = pend_br_q;
        case (state_q)
            IDLE: begin
                if (ev) begin
                    if (bus.stall) begin
                        pend_pc_d = sel_pc;
                        pend_br_d = sel_br;
                        state_d   = HOLD;
                    end else begin
                        fire    = 1'b1;
                        fire_pc = sel_pc;
                        fire_br = sel_br;
                        state_d = SETTLE;
                    end
                end
            end
            HOLD: begin
                if (!bus.stall) begin
                    fire    = 1'b1;
                    state_d = SETTLE;
                end
            end
            // Events seen here belong to wrong-path instructions.
            SETTLE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pend_pc_q <= 32'h0;
            pend_br_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_pc_q <= pend_pc_d;
            pend_br_q <= pend_br_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q       <= 1'b0;
            pc_q          <= 32'h0;
            flush_if_id_q <= 1'b0;
            flush_id_ex_q <= 1'b0;
            count_q       <= 16'h0;
        end else begin
            valid_q       <= fire;
            flush_if_id_q <= fire;
            flush_id_ex_q <= fire & fire_br;
            if (fire) begin
                pc_q <= fire_pc;
            end
            if (fire && (count_q != CNT_SAT)) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    assign bus.redirect_valid = valid_q;
    assign bus.redirect_pc    = pc_q;
    assign bus.flush_if_id    = flush_if_id_q;
    assign bus.flush_id_ex    = flush_id_ex_q;
    assign bus.busy           = (state_q != IDLE);
    assign bus.redirect_count = count_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Randomized and directed bench for pc_redirect_ctrl against a cycle-indexed
// reference model (pending queue plus quiet window), with a small-limit saturation instance.
module tb_pc_redirect_ctrl;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    pc_redirect_ctrl_if bus();
    pc_redirect_ctrl_if bus_s();

    pc_redirect_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    pc_redirect_ctrl #(.CNT_SAT(16'd5)) dut_sat (
        .clock (clock),
        .reset (reset),
        .bus   (bus_s)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: redirects are numbered by edge; an issued redirect
    // makes the following edge deaf, a stalled one waits in a queue.
    logic [31:0] m_pend_pc[$];
    bit          m_pend_br[$];
    int          m_cyc;
    int          m_quiet;
    bit          e_valid;
    bit          e_fie;
    bit          e_busy;
    logic [31:0] e_pc;
    int          e_count;

    task automatic model_clear();
        m_pend_pc.delete();
        m_pend_br.delete();
        m_cyc   = 0;
        m_quiet = 0;
        e_valid = 0;
        e_fie   = 0;
        e_busy  = 0;
        e_pc    = 32'h0;
        e_count = 0;
    endtask

    task automatic model_edge();
        bit          emit = 0;
        bit          br   = 0;
        logic [31:0] tgt  = 32'h0;
        if (m_pend_pc.size() > 0) begin
            if (!bus.stall) begin
                emit = 1;
                tgt  = m_pend_pc.pop_front();
                br   = m_pend_br.pop_front();
            end
        end else if (m_cyc >= m_quiet && (bus.branch_taken_ex || bus.jump_id)) begin
            if (bus.branch_taken_ex) begin
                tgt = bus.branch_target_ex;
                br  = 1;
            end else begin
                tgt = (bus.pc_plus_4_id & 32'hF000_0000) | (32'(bus.jump_addr_id) * 4);
                br  = 0;
            end
            if (bus.stall) begin
                m_pend_pc.push_back(tgt);
                m_pend_br.push_back(br);
            end else begin
                emit = 1;
            end
        end
        e_valid = emit;
        e_fie   = emit && br;
        if (emit) begin
            e_pc    = tgt;
            e_count = (e_count < 65535) ? e_count + 1 : 65535;
            m_quiet = m_cyc + 2;
        end
        e_busy = emit || (m_pend_pc.size() > 0);
        m_cyc++;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 32'(bus.redirect_valid), 32'(e_valid));
        chk({tag, ".fiid"},  32'(bus.flush_if_id),    32'(e_valid));
        chk({tag, ".fiex"},  32'(bus.flush_id_ex),    32'(e_fie));
        chk({tag, ".pc"},    bus.redirect_pc,         e_pc);
        chk({tag, ".busy"},  32'(bus.busy),           32'(e_busy));
        chk({tag, ".count"}, 32'(bus.redirect_count), 32'(e_count));
    endtask

    task automatic drive(input bit st, input bit j, input logic [25:0] ja,
                         input logic [31:0] p4, input bit b, input logic [31:0] bt);
        bus.stall            = st;
        bus.jump_id          = j;
        bus.jump_addr_id     = ja;
        bus.pc_plus_4_id     = p4;
        bus.branch_taken_ex  = b;
        bus.branch_target_ex = bt;
    endtask

    task automatic drive_rand(input bit st);
        drive(st, ($urandom_range(0, 9) < 4), 26'($urandom), $urandom,
              ($urandom_range(0, 9) < 3), $urandom);
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clock);
        #1;
        check_all(tag);
    endtask

    // Reset is raised mid-cycle so the clear is seen without a clock edge.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        model_clear();
        check_all(tag);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 26'h0, 32'h0, 0, 32'h0);
        bus_s.stall = 0; bus_s.jump_id = 0; bus_s.jump_addr_id = 26'h0;
        bus_s.pc_plus_4_id = 32'h0; bus_s.branch_taken_ex = 0; bus_s.branch_target_ex = 32'h0;
        @(posedge clock);
        #1;
        do_reset("rst");

        // Unstalled jump, then SETTLE, then IDLE
        drive(0, 1, 26'h0000010, 32'h4000_0004, 0, 32'h0);
        step("jmp");
        chk("jmp.pc_const", bus.redirect_pc, 32'h4000_0040);
        chk("jmp.cnt_const", 32'(bus.redirect_count), 32'd1);
        drive(0, 0, 26'h0, 32'h0, 0, 32'h0);
        step("jmp.settle");
        step("jmp.idle");

        // Branch beats a same-cycle jump
        drive(0, 1, 26'h12345, 32'h8000_0000, 1, 32'h0000_0100);
        step("both");
        chk("both.pc_const", bus.redirect_pc, 32'h0000_0100);
        chk("both.fiex_const", 32'(bus.flush_id_ex), 32'd1);
        drive(0, 0, 26'h0, 32'h0, 0, 32'h0);
        step("both.settle");
        step("both.idle");

        // Stalled capture with changing inputs, release after 3 stalled cycles
        drive(1, 1, 26'h3FFFFFF, 32'hF000_0008, 0, 32'h0);
        step("hold0");
        for (int i = 0; i < 2; i++) begin
            drive_rand(1);
            step("hold");
            chk("hold.busy_const", 32'(bus.busy), 32'd1);
        end
        drive(0, 0, 26'h0, 32'h0, 0, 32'h0);
        step("hold.rel");
        chk("hold.pc_const", bus.redirect_pc, 32'hFFFF_FFFC);
        step("hold.settle");
        step("hold.idle");

        // Jump held high for 4 cycles: only every other edge redirects
        drive(0, 1, 26'h0000100, 32'h1000_0000, 0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step("train");
            chk("train.valid_const", 32'(bus.redirect_valid), (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        drive(0, 0, 26'h0, 32'h0, 0, 32'h0);
        step("train.idle");

        // Reset while holding discards the pending redirect
        drive(1, 1, 26'h0000ABC, 32'h2000_0000, 0, 32'h0);
        step("rhold");
        do_reset("rhold.rst");
        drive(0, 0, 26'h0, 32'h0, 0, 32'h0);
        for (int i = 0; i < 3; i++) step("rhold.after");
        chk("rhold.cnt_const", 32'(bus.redirect_count), 32'd0);

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset("rnd.rst");
            end
            drive_rand($urandom_range(0, 9) < 3);
            step("rnd");
        end
        drive(0, 0, 26'h0, 32'h0, 0, 32'h0);
        step("rnd.end");

        // Saturation on a low-limit instance: count must stick at the limit
        bus_s.jump_id      = 1;
        bus_s.jump_addr_id = 26'h0000020;
        for (int i = 0; i < 16; i++) begin
            @(posedge clock);
            #1;
            chk("sat.count", 32'(bus_s.redirect_count), 32'((i / 2 + 1 < 5) ? i / 2 + 1 : 5));
            chk("sat.valid", 32'(bus_s.redirect_valid), (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        bus_s.jump_id = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_redirect_ctrl.md
PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports are listed below as name, direction, width, meaning.
REQ-002 `clock` SHALL be an input, 1 bit wide: rising-edge clock for all state.
REQ-003 `reset` SHALL be an input, 1 bit wide: asynchronous active-high reset.
REQ-004 `stall` SHALL be an input, 1 bit wide: pipeline frozen this cycle (hazard or memory wait).
REQ-005 `jump_id` SHALL be an input, 1 bit wide: J-type jump decoded in ID.
REQ-006 `jump_addr_id` SHALL be an input, 26 bits wide: instruction index field of the ID jump.
REQ-007 `pc_plus_4_id` SHALL be an input, 32 bits wide: PC+4 of the ID instruction.
REQ-008 `branch_taken_ex` SHALL be an input, 1 bit wide: resolved taken branch in EX.
REQ-009 `branch_target_ex` SHALL be an input, 32 bits wide: target of the EX branch.
REQ-010 `redirect_valid` SHALL be an output, 1 bit wide: registered one-cycle pulse; PC mux selects `redirect_pc`.
REQ-011 `redirect_pc` SHALL be an output, 32 bits wide: registered next-PC value.
REQ-012 `flush_if_id` SHALL be an output, 1 bit wide: registered pulse that squashes the IF/ID register.
REQ-013 `flush_id_ex` SHALL be an output, 1 bit wide: registered pulse that squashes the ID/EX register; asserted for branch redirects only.
REQ-014 `busy` SHALL be an output, 1 bit wide: high while in any state other than IDLE.
REQ-015 `redirect_count` SHALL be an output, 16 bits wide: saturating count of issued redirects.

Function
REQ-016 Jump target SHALL be {pc_plus_4_id[31:28], jump_addr_id, 2'b00}; no carry into bits 31:28.
REQ-017 The FSM SHALL have exactly three states: IDLE, HOLD, SETTLE.
REQ-018 The following SHALL hold in IDLE:
- An event is branch_taken_ex=1 or jump_id=1.
- If both are high, the branch SHALL win (it is the older instruction) and the jump SHALL be discarded.
REQ-019 IDLE, event, stall=0 SHALL cause the following on the next edge:
- redirect_valid=1, redirect_pc=selected target, flush_if_id=1.
- flush_id_ex=1 if the source is a branch, else 0.
- Transition to SETTLE.
REQ-020 IDLE, event, stall=1 SHALL cause the following:
- Latch target and source type.
- Transition to HOLD.
- All pulse outputs stay 0.
REQ-021 In HOLD, while stall=1, the FSM SHALL remain in HOLD with outputs 0, and the latched target SHALL be unchanged.
REQ-022 In HOLD, on the first edge with stall=0, the block SHALL emit the latched redirect with the same pulse set as REQ-019 and transition to SETTLE.
REQ-023 In HOLD, jump_id and branch_taken_ex SHALL be ignored.
REQ-024 SETTLE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-025 In SETTLE, jump_id and branch_taken_ex SHALL be ignored, because the ID/EX contents are wrong-path instructions.
REQ-026 redirect_valid, flush_if_id and flush_id_ex SHALL each be high for exactly one cycle per redirect and never high outside that cycle.
REQ-027 redirect_pc SHALL hold its last value when redirect_valid=0.
REQ-028 redirect_count SHALL increment by 1 in the cycle redirect_valid is asserted and SHALL saturate at 16'hFFFF, never wrapping to 0.
REQ-029 Latency SHALL be one cycle from a sampled unstalled event to redirect_valid, and one cycle from stall deassertion to redirect_valid when in HOLD.
REQ-030 Minimum spacing between two redirects SHALL be 2 cycles (redirect cycle plus SETTLE).

Reset
REQ-031 While reset=1, asynchronously: state=IDLE, redirect_valid=0, redirect_pc=32'h0, flush_if_id=0, flush_id_ex=0, busy=0, redirect_count=16'h0, latched target and source cleared.
REQ-032 Reset asserted in HOLD or SETTLE SHALL discard the pending redirect; no pulse SHALL be emitted after reset release.
REQ-033 After reset deasserts, the first event SHALL be sampled on the next rising edge.

Verification
REQ-034 Unstalled jump: jump_id=1, jump_addr_id=26'h0000010, pc_plus_4_id=32'h4000_0004, stall=0 -> next cycle redirect_valid=1, redirect_pc=32'h4000_0040, flush_if_id=1, flush_id_ex=0, count=1; then SETTLE one cycle, then IDLE.
REQ-035 Simultaneous events: branch_taken_ex=1 with branch_target_ex=32'h0000_0100 and jump_id=1 in the same cycle -> redirect_pc=32'h0000_0100, flush_id_ex=1; the jump is never emitted.
REQ-036 Stalled capture: jump with pc_plus_4_id=32'hF000_0008, jump_addr_id=26'h3FFFFFF, stall=1 for 3 cycles while inputs change -> busy=1, no pulses; on the edge after stall drops, redirect_pc=32'hFFFF_FFFC.
REQ-037 SETTLE suppression: jump_id held high for 4 consecutive cycles with stall=0 -> redirects in cycles 2 and 4 only; count=2.
REQ-038 Reset mid-HOLD: enter HOLD, assert reset for 1 cycle, release with stall=0 -> no redirect_valid pulse, count=0, state IDLE.
REQ-039 Saturation: preload by issuing 65535 redirects, then one more -> redirect_count stays 16'hFFFF.
